// File: rtl/param_loader_pkg.sv
// Shared word width, loader state encoding and the layer-length rule used by
// the parameter loader and its node/word counter.
package param_loader_pkg;

    localparam int N     = 8;
    localparam int BUS_W = 2 * N;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    // Highest word index of a node: its fan-in (weights) -- the bias sits at this index.
    function automatic logic [7:0] layer_len(input logic [7:0] node,
                                             input int sx, input int sl1,
                                             input int sl2, input int sl);
        if (int'(node) >= sl2 + sl)
            return 8'(sx);
        else if (int'(node) >= sl)
            return 8'(sl1);
        else
            return 8'(sl2);
    endfunction

endpackage

// File: rtl/param_loader_if.sv
// Host-side stream and per-node write-enable signals of the parameter loader.
interface param_loader_if #(
    parameter int nd = 8,
    parameter int W  = 16
) ();
    logic                start;
    logic                abort;
    logic signed [W-1:0] s_data;
    logic                s_valid;
    logic                s_ready;
    logic [nd-1:0]       we;
    logic                busy;
    logic                done;
    logic [7:0]          node;

    modport master (
        output start, abort, s_data, s_valid,
        input  s_ready, we, busy, done, node
    );

    modport slave (
        input  start, abort, s_data, s_valid,
        output s_ready, we, busy, done, node
    );
endinterface

// File: rtl/loader_ctr.sv
// Node/word counter pair: walks nodes nd-1..0, each for its layer's fan-in plus bias.
module loader_ctr
    import param_loader_pkg::*;
#(
    parameter int sx  = 4,
    parameter int sl1 = 3,
    parameter int sl2 = 3,
    parameter int sl  = 2,
    parameter int nd  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    output logic [7:0] node,
    output logic [7:0] word,
    output logic       last_word,
    output logic       last_node
);
    logic [7:0] node_q, node_d;
    logic [7:0] word_q, word_d;

    always_comb begin
        last_word = (word_q == layer_len(node_q, sx, sl1, sl2, sl));
        last_node = (node_q == 8'd0);
        node_d    = node_q;
        word_d    = word_q;
        if (clr) begin
            node_d = 8'(nd - 1);
            word_d = 8'd0;
        end else if (inc) begin
            if (last_word) begin
                word_d = 8'd0;
                // Wrapping back to the first node leaves the counter ready for the next load.
                node_d = last_node ? 8'(nd - 1) : node_q - 8'd1;
            end else begin
                word_d = word_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            node_q <= 8'(nd - 1);
            word_q <= 8'd0;
        end else begin
            node_q <= node_d;
            word_q <= word_d;
        end
    end

    assign node = node_q;
    assign word = word_q;

endmodule

// File: rtl/param_loader.sv
// Streams host parameter words onto the shared network bus, one-hot selecting
// the node shift register to fill; one cycle from acceptance to bus write.
module param_loader
    import param_loader_pkg::*;
#(
    parameter int sx  = 4,
    parameter int sl1 = 3,
    parameter int sl2 = 3,
    parameter int sl  = 2,
    parameter int nd  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    param_loader_if.slave           host,
    inout  wire signed [BUS_W-1:0]  bus
);
    if (nd != sl1 + sl2 + sl) begin : g_nd_check
        $error("param_loader: nd must equal sl1+sl2+sl");
    end

    state_t                   state_q;
    logic [nd-1:0]            we_q, we_d;
    logic signed [BUS_W-1:0]  data_q;
    logic                     accept, ctr_clr;
    logic [7:0]               ctr_node;
    logic [7:0]               unused_word;
    logic                     last_word, last_node;

    // Abort gates ready so a word offered in the abort cycle is never taken.
    assign host.s_ready = (state_q == ST_LOAD) && !host.abort;
    assign accept       = host.s_valid && host.s_ready;
    assign ctr_clr      = (state_q == ST_IDLE) && host.start;
    assign we_d         = accept ? (nd'(1) << ctr_node) : '0;

    loader_ctr #(
        .sx (sx),
        .sl1(sl1),
        .sl2(sl2),
        .sl (sl),
        .nd (nd)
    ) u_ctr (
        .clk      (clk),
        .rst      (rst),
        .clr      (ctr_clr),
        .inc      (accept),
        .node     (ctr_node),
        .word     (unused_word),
        .last_word(last_word),
        .last_node(last_node)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            we_q    <= '0;
        end else begin
            we_q <= we_d;
            case (state_q)
                ST_IDLE: if (host.start) state_q <= ST_LOAD;
                ST_LOAD: begin
                    if (host.abort)
                        state_q <= ST_IDLE;
                    else if (accept && last_word && last_node)
                        state_q <= ST_FIN;
                end
                ST_FIN:  state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept) data_q <= host.s_data;
    end

    assign host.we   = we_q;
    assign host.busy = (state_q == ST_LOAD);
    assign host.done = (state_q == ST_FIN);
    assign host.node = ctr_node;

    // Reset clears we_q asynchronously, so the bus releases without waiting for a clock.
    assign bus = (|we_q) ? data_q : 'z;

endmodule

// File: tb/tb_param_loader.sv
// Randomized self-checking bench for param_loader against a word-list reference model.
module tb_param_loader;
    import param_loader_pkg::*;

    localparam int SX = 4, SL1 = 3, SL2 = 3, SL = 2, ND = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    wire signed [BUS_W-1:0] bus;

    param_loader_if #(.nd(ND), .W(BUS_W)) h ();

    pulldown pd_bus [BUS_W-1:0] (bus);

    param_loader #(.sx(SX), .sl1(SL1), .sl2(SL2), .sl(SL), .nd(ND)) dut (
        .clk (clk),
        .rst (rst),
        .host(h.slave),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: ordered list of target nodes, one entry per word of a load.
    int          node_of [0:255];
    int          total_w;
    bit          m_ld, m_fin;
    int          m_idx;
    logic [ND-1:0]      exp_we;
    logic [BUS_W-1:0]   exp_bus;

    function automatic logic [BUS_W-1:0] exp_bv();
        return (exp_we != '0) ? exp_bus : '0;
    endfunction

    task automatic model_reset();
        m_ld = 1'b0; m_fin = 1'b0; m_idx = 0; exp_we = '0; exp_bus = '0;
    endtask

    task automatic step(input logic sv, input logic [BUS_W-1:0] d,
                        input logic st, input logic ab);
        bit acc;
        h.s_valid = sv; h.s_data = d; h.start = st; h.abort = ab;
        acc = sv && m_ld && !ab;
        @(posedge clk);
        exp_we = acc ? (ND'(1) << node_of[m_idx]) : '0;
        if (acc) begin
            exp_bus = d;
            m_idx++;
        end
        if (m_fin) m_fin = 1'b0;
        else if (m_ld) begin
            if (ab) m_ld = 1'b0;
            else if (acc && m_idx == total_w) begin m_ld = 1'b0; m_fin = 1'b1; end
        end else if (st) begin
            m_ld = 1'b1; m_idx = 0;
        end
        #1;
        h.start = 1'b0; h.abort = 1'b0;
    endtask

    task automatic test_reset();
        h.start = 0; h.abort = 0; h.s_valid = 0; h.s_data = '0;
        rst = 1'b1;
        #3;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        step(1'b0, '0, 1'b0, 1'b0);
        checks += 6;
        if (h.we !== '0)    begin errors++; $display("FAIL reset_we got %h want 00", h.we); end
        if (bus !== '0)     begin errors++; $display("FAIL reset_bus got %h want z(pulled 0)", bus); end
        if (h.s_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", h.s_ready); end
        if (h.busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %b want 0", h.busy); end
        if (h.done !== 1'b0)    begin errors++; $display("FAIL reset_done got %b want 0", h.done); end
        if (h.node !== 8'(ND-1)) begin errors++; $display("FAIL reset_node got %0d want %0d", h.node, ND-1); end
    endtask

    task automatic test_full_load();
        int pulses = 0;
        step(1'b0, '0, 1'b1, 1'b0);
        for (int k = 1; k <= total_w; k++) begin
            step(1'b1, BUS_W'(k), 1'b0, 1'b0);
            if (h.we != '0) pulses++;
            checks += 3;
            if (h.we !== exp_we)   begin errors++; $display("FAIL full_we k=%0d got %h want %h", k, h.we, exp_we); end
            if (bus !== exp_bv())  begin errors++; $display("FAIL full_bus k=%0d got %h want %h", k, bus, exp_bv()); end
            if (h.done !== m_fin)  begin errors++; $display("FAIL full_done k=%0d got %b want %b", k, h.done, m_fin); end
        end
        step(1'b0, '0, 1'b0, 1'b0);
        checks += 3;
        if (h.done !== 1'b0 || h.busy !== 1'b0) begin errors++; $display("FAIL full_end done=%b busy=%b want 0 0", h.done, h.busy); end
        if (bus !== '0)        begin errors++; $display("FAIL full_endbus got %h want z(pulled 0)", bus); end
        if (pulses !== total_w) begin errors++; $display("FAIL full_pulses got %0d want %0d", pulses, total_w); end
    endtask

    task automatic test_stalls();
        int pulses = 0;
        int cyc = 0;
        bit saw_done = 1'b0;
        step(1'b0, '0, 1'b1, 1'b0);
        while ((m_ld || m_fin) && cyc < 400) begin
            step(1'($urandom_range(0, 1)), BUS_W'($urandom), 1'b0, 1'b0);
            cyc++;
            if (h.we != '0) pulses++;
            if (h.done) saw_done = 1'b1;
            checks += 3;
            if (h.we !== exp_we)  begin errors++; $display("FAIL stall_we c=%0d got %h want %h", cyc, h.we, exp_we); end
            if (bus !== exp_bv()) begin errors++; $display("FAIL stall_bus c=%0d got %h want %h", cyc, bus, exp_bv()); end
            if (h.busy !== m_ld)  begin errors++; $display("FAIL stall_busy c=%0d got %b want %b", cyc, h.busy, m_ld); end
        end
        checks += 3;
        if (cyc >= 400) begin errors++; $display("FAIL stall_timeout cycles=%0d want <400", cyc); end
        if (pulses !== total_w) begin errors++; $display("FAIL stall_pulses got %0d want %0d", pulses, total_w); end
        if (!saw_done) begin errors++; $display("FAIL stall_done got 0 want 1"); end
    endtask

    task automatic test_abort();
        bit saw_done = 1'b0;
        step(1'b0, '0, 1'b1, 1'b0);
        for (int k = 1; k <= 11; k++) step(1'b1, BUS_W'(k), 1'b0, 1'b0);
        step(1'b1, BUS_W'(12), 1'b0, 1'b1);
        checks += 3;
        if (h.we !== '0)     begin errors++; $display("FAIL abort_we got %h want 00", h.we); end
        if (bus !== '0)      begin errors++; $display("FAIL abort_bus got %h want z(pulled 0)", bus); end
        if (h.busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", h.busy); end
        for (int k = 0; k < 3; k++) begin
            step(1'b1, BUS_W'(99), 1'b0, 1'b0);
            if (h.done || h.we != '0) saw_done = 1'b1;
        end
        checks += 1;
        if (saw_done) begin errors++; $display("FAIL abort_quiet got activity want none"); end
        step(1'b0, '0, 1'b1, 1'b0);
        checks += 1;
        if (h.node !== 8'(ND-1)) begin errors++; $display("FAIL abort_restart_node got %0d want %0d", h.node, ND-1); end
        for (int k = 1; k <= total_w; k++) begin
            step(1'b1, BUS_W'(100 + k), 1'b0, 1'b0);
            checks += 2;
            if (h.we !== exp_we)  begin errors++; $display("FAIL abort_re_we k=%0d got %h want %h", k, h.we, exp_we); end
            if (bus !== exp_bv()) begin errors++; $display("FAIL abort_re_bus k=%0d got %h want %h", k, bus, exp_bv()); end
        end
        step(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        step(1'b0, '0, 1'b1, 1'b0);
        for (int k = 1; k <= 20; k++) step(1'b1, BUS_W'(200 + k), 1'b0, 1'b0);
        checks += 1;
        if (h.we !== exp_we) begin errors++; $display("FAIL rmid_pre_we got %h want %h", h.we, exp_we); end
        #2 rst = 1'b1;
        #1;
        checks += 3;
        if (h.we !== '0)     begin errors++; $display("FAIL rmid_we got %h want 00", h.we); end
        if (bus !== '0)      begin errors++; $display("FAIL rmid_bus got %h want z(pulled 0)", bus); end
        if (h.done !== 1'b0) begin errors++; $display("FAIL rmid_done got %b want 0", h.done); end
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        step(1'b1, BUS_W'(7), 1'b0, 1'b0);
        checks += 3;
        if (h.busy !== 1'b0)     begin errors++; $display("FAIL rmid_busy got %b want 0", h.busy); end
        if (h.node !== 8'(ND-1)) begin errors++; $display("FAIL rmid_node got %0d want %0d", h.node, ND-1); end
        if (h.we !== '0)         begin errors++; $display("FAIL rmid_idle_we got %h want 00", h.we); end
    endtask

    task automatic test_ignored();
        step(1'b0, '0, 1'b0, 1'b1);
        checks += 2;
        if (h.busy !== 1'b0)     begin errors++; $display("FAIL ign_abort_busy got %b want 0", h.busy); end
        if (h.node !== 8'(ND-1)) begin errors++; $display("FAIL ign_abort_node got %0d want %0d", h.node, ND-1); end
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        checks += 2;
        if (h.busy !== 1'b1)     begin errors++; $display("FAIL ign_start_busy got %b want 1", h.busy); end
        if (h.node !== 8'(ND-1)) begin errors++; $display("FAIL ign_start_node got %0d want %0d", h.node, ND-1); end
        step(1'b1, 16'h8001, 1'b0, 1'b0);
        checks += 2;
        if (bus !== 16'h8001) begin errors++; $display("FAIL ign_neg_bus got %h want 8001", bus); end
        if (!($signed(bus) < 0)) begin errors++; $display("FAIL ign_neg_sign got %0d want negative", $signed(bus)); end
        for (int k = 2; k <= total_w; k++) begin
            step(1'b1, BUS_W'($urandom), (k == 10), 1'b0);
            checks += 2;
            if (h.we !== exp_we)  begin errors++; $display("FAIL ign_we k=%0d got %h want %h", k, h.we, exp_we); end
            if (bus !== exp_bv()) begin errors++; $display("FAIL ign_bus k=%0d got %h want %h", k, bus, exp_bv()); end
        end
        checks += 1;
        if (h.done !== 1'b1) begin errors++; $display("FAIL ign_fin_done got %b want 1", h.done); end
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        checks += 2;
        if (h.busy !== 1'b0) begin errors++; $display("FAIL ign_fin_start_busy got %b want 0", h.busy); end
        if (h.done !== 1'b0) begin errors++; $display("FAIL ign_fin_start_done got %b want 0", h.done); end
    endtask

    initial begin
        total_w = 0;
        for (int nd_i = ND - 1; nd_i >= 0; nd_i--) begin
            int len;
            len = (nd_i >= SL2 + SL) ? SX + 1 : (nd_i >= SL) ? SL1 + 1 : SL2 + 1;
            for (int j = 0; j < len; j++) begin
                node_of[total_w] = nd_i;
                total_w++;
            end
        end
        model_reset();
        test_reset();
        test_full_load();
        test_stalls();
        test_abort();
        test_reset_mid();
        test_ignored();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
